// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the 8-by-4 sequential restoring divider.
`default_nettype none

package divider_pkg;
  localparam int DW    = 8;
  localparam int VW    = 4;
  localparam int CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;
endpackage

`default_nettype wire

// File: rtl/seq_divider_8by4_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
`default_nettype none

module div_step
  import divider_pkg::*;
(
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_next_o,
  output logic          q_bit_o
);

  logic [VW:0] w_shifted;
  logic [VW:0] w_trial;
  // The partial remainder stays below the divisor, so its top bit never carries information.
  logic        unused_r_msb;

  assign unused_r_msb = r_i[VW];
  assign w_shifted    = {r_i[VW-1:0], bit_i};
  assign w_trial      = w_shifted - {1'b0, divisor_i};
  assign q_bit_o      = ~w_trial[VW];
  assign r_next_o     = q_bit_o ? w_trial : w_shifted;

endmodule

`default_nettype wire

// File: rtl/seq_divider_8by4.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
`default_nettype none

module seq_divider_8by4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quotient_o,
  output logic [VW-1:0] remainder_o,
  output logic          div_by_zero_o
);
  import divider_pkg::div_state_t;
  import divider_pkg::IDLE;
  import divider_pkg::RUN;
  import divider_pkg::CNT_W;

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    work_q;
  logic [VW-1:0]    div_q;
  logic [VW:0]      r_q;
  logic             busy_q;
  logic             done_q;
  logic [DW-1:0]    quot_q;
  logic [VW-1:0]    rem_q;
  logic             dbz_q;

  logic [VW:0]      r_d;
  logic             q_bit;
  logic [DW-1:0]    work_d;

  div_step u_step (
    .r_i       (r_q),
    .bit_i     (work_q[DW-1]),
    .divisor_i (div_q),
    .r_next_o  (r_d),
    .q_bit_o   (q_bit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so after
  // the last step the same register holds the finished quotient.
  assign work_d = {work_q[DW-2:0], q_bit};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      div_q   <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              done_q <= 1'b1;
              quot_q <= {DW{1'b1}};
              rem_q  <= '0;
              dbz_q  <= 1'b1;
            end else begin
              work_q  <= dividend_i;
              div_q   <= divisor_i;
              r_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          r_q    <= r_d;
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DW - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= work_d;
            rem_q   <= r_d[VW-1:0];
            dbz_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

`default_nettype wire

// File: doc/seq_divider_8by4.md
# seq_divider_8by4

Sequential restoring divider: divides an 8-bit dividend by a 4-bit divisor and produces an 8-bit quotient and a 4-bit remainder. It resolves one quotient bit per clock under a start/busy/done handshake. It is the inverse of the team's 4-bit × 4-bit array multiplier: for any A, B with B ≠ 0, dividend = A·B and divisor = B gives quotient = A and remainder = 0. It sits beside the multiplier in the arithmetic datapath and is used for result checking and rescaling.

## Interface
Parameters:
- DW, 8, dividend and quotient width (fixed at 8 for this release)
- VW, 4, divisor and remainder width (fixed at 4)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  request; sampled only while busy = 0
- dividend  input  8  numerator; captured when start is accepted
- divisor  input  4  denominator; captured when start is accepted
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results update
- quotient  output  8  registered result; held until the next completion
- remainder  output  4  registered result; held until the next completion
- div_by_zero  output  1  registered; set on completion when the captured divisor = 0, otherwise cleared

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN when start = 1 and divisor ≠ 0.
  - RUN → IDLE after the 8th step.
  - Divisor = 0 stays in IDLE (zero-divide path, below).
- Accept: at the accept edge, the block loads the working dividend shift register from `dividend` and the divisor register from `divisor`, clears the 5-bit partial remainder, and sets the step counter to 0.
- Each RUN edge performs one restoring step:
  - r' = {r[3:0], dividend_msb}; the dividend register shifts left by 1.
  - trial = r' − {1'b0, divisor}, 5-bit.
  - If trial[4] = 0: r ← trial and quotient bit = 1. Otherwise: r ← r' and bit = 0.
  - The quotient bit shifts into the LSB of the working quotient.
- After step 8: quotient ← working quotient, remainder ← r[3:0], div_by_zero ← 0, done = 1, busy = 0.
- Zero divide: start with divisor = 0 is accepted from IDLE. On the next edge: quotient = 8'hFF, remainder = 4'h0, div_by_zero = 1, done = 1. No RUN cycles occur.
- start while busy = 1 is ignored; operands on the bus are don't-care.
- Back-to-back: start may be asserted in the same cycle as done, because busy is already 0. That start is accepted with no bubble.
- All arithmetic is unsigned. The remainder is always < divisor. The 5-bit partial remainder prevents trial overflow.

## Timing
- Reset values: busy = 0, done = 0, quotient = 8'h00, remainder = 4'h0, div_by_zero = 0; FSM = IDLE; counter = 0.
- Accept at edge E0. busy = 1 from E0 through E8. done = 1 for exactly the cycle following E8. Latency is 8 cycles from accept to valid results, and the throughput is 1 division per 8 cycles.
- Zero divide: done rises 1 cycle after accept. busy stays 0.
- rst_n asserted mid-operation aborts immediately: all outputs return to their reset values and no done is produced. After rst_n deasserts, a new start is accepted normally.
- quotient, remainder and div_by_zero change only on the done edge. They are stable at all other times.

## Structure
- Package `divider_pkg` holds:
  - DW and VW constants;
  - `div_state_t` enum {IDLE, RUN};
  - the step-counter width localparam (3 bits).
- Sub-module `div_step`: purely combinational, one restoring step.
  - Inputs: r (5), next dividend bit, divisor (4).
  - Outputs: r_next (5), q_bit.
  - Instantiated once. The top-level file holds the FSM, the counter and the registers.

## Test plan
- Reset, then dividend = 143 (11·13), divisor = 11 → after 8 cycles done pulses once; quotient = 13, remainder = 0, div_by_zero = 0.
- dividend = 200, divisor = 7 → quotient = 28, remainder = 4. dividend = 255, divisor = 1 → quotient = 255, remainder = 0. dividend = 5, divisor = 15 → quotient = 0, remainder = 5.
- divisor = 0, dividend = 77 → done 1 cycle after accept; quotient = 8'hFF, remainder = 0, div_by_zero = 1; busy never rises. The next valid division clears div_by_zero.
- Pulse start again with dividend = 9, divisor = 3 during cycle 4 of a 200/7 run → the pulse is ignored; only 28 r 4 is reported; done pulses once.
- Assert start in the done cycle with dividend = 100, divisor = 10 → second done exactly 8 cycles later with quotient = 10, remainder = 0.
- Drop rst_n at cycle 5 of a division → busy, done and the result outputs read zero immediately. No done appears after release, and a fresh 143/11 completes correctly.
- Randomized cross-check: for all A, B in 1..15, dividend = A·B, divisor = B → quotient = A, remainder = 0.
